// File: rtl/axi_hp_wr_arb_pkg.sv
// Shared types and AXI3 HP constants for the HP write arbiter.
// Declares package axi_hp_pkg: FSM state encoding, BRESP/burst codes, HP ID and length widths.
package axi_hp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AWR  = 2'd1,
    ST_WDAT = 2'd2,
    ST_BRSP = 2'd3
  } state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam int         HP_ID_W      = 6;
  localparam int         HP_LEN_W     = 4;

endpackage

// File: rtl/axi_hp_wr_arb_rr_arb.sv
// Round-robin pick: first set request at or after ptr_i, wrapping modulo RN.
module rr_arb #(
  parameter int RN = 2
) (
  input  logic [RN-1:0]         req_i,
  input  logic [$clog2(RN)-1:0] ptr_i,
  output logic                  any_o,
  output logic [$clog2(RN)-1:0] idx_o
);

  localparam int PW = $clog2(RN);

  logic          hi_hit;
  logic [PW-1:0] lo_idx;
  logic [PW-1:0] hi_idx;

  // Descending loops leave the lowest matching index in place.
  always_comb begin
    any_o  = 1'b0;
    hi_hit = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int k = RN - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        any_o  = 1'b1;
        lo_idx = PW'(k);
      end
      if (req_i[k] && (k >= int'(ptr_i))) begin
        hi_hit = 1'b1;
        hi_idx = PW'(k);
      end
    end
    idx_o = hi_hit ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/axi_hp_wr_arb.sv
// Round-robin arbiter sharing one AXI3 HP write port between RN DMA writers, one burst at a time.
// Optional B-response watchdog enabled by defining AXI_HP_WR_ARB_TMO_EN.
module axi_hp_wr_arb
  import axi_hp_pkg::*;
#(
  parameter int RN  = 2,
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int TMO = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [RN-1:0]                req_valid_i,
  output logic [RN-1:0]                req_ready_o,
  input  logic [RN*AW-1:0]             req_addr_i,
  input  logic [RN*HP_LEN_W-1:0]       req_len_i,
  input  logic [RN*DW-1:0]             req_wdata_i,
  input  logic [RN*DW/8-1:0]           req_wstrb_i,
  input  logic [RN-1:0]                req_wvalid_i,
  output logic [RN-1:0]                req_wready_o,
  output logic [RN-1:0]                req_done_o,
  output logic [RN-1:0]                req_err_o,
  output logic [$clog2(RN)-1:0]        grant_o,
  output logic                         busy_o,
  output state_e                       dbg_state_o,
  output logic [AW-1:0]                axi_awaddr_o,
  output logic [HP_LEN_W-1:0]          axi_awlen_o,
  output logic [HP_ID_W-1:0]           axi_awid_o,
  output logic [2:0]                   axi_awsize_o,
  output logic [1:0]                   axi_awburst_o,
  output logic                         axi_awvalid_o,
  input  logic                         axi_awready_i,
  output logic [DW-1:0]                axi_wdata_o,
  output logic [DW/8-1:0]              axi_wstrb_o,
  output logic [HP_ID_W-1:0]           axi_wid_o,
  output logic                         axi_wlast_o,
  output logic                         axi_wvalid_o,
  input  logic                         axi_wready_i,
  input  logic [HP_ID_W-1:0]           axi_bid_i,
  input  logic [1:0]                   axi_bresp_i,
  input  logic                         axi_bvalid_i,
  output logic                         axi_bready_o
);

  localparam int         GW     = $clog2(RN);
  localparam int         SW     = DW / 8;
  localparam logic [2:0] AXSIZE = 3'($clog2(SW));

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
  // Valid never waits on ready; payload holds steady while valid is up and ready is low.

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [HP_LEN_W-1:0]   len_q, len_d;
  logic [HP_LEN_W-1:0]   cnt_q, cnt_d;
  logic                  arb_any;
  logic [GW-1:0]         arb_idx;
  logic [RN-1:0]         grant_oh;
  logic [HP_ID_W-1:0]    grant_id;
  logic                  tmo_hit;
  logic                  idle_bready;

  rr_arb #(.RN(RN)) u_rr_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .any_o (arb_any),
    .idx_o (arb_idx)
  );

  assign grant_oh    = {{(RN-1){1'b0}}, 1'b1} << grant_q;
  assign grant_id    = {{(HP_ID_W-GW){1'b0}}, grant_q};
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef AXI_HP_WR_ARB_TMO_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Late B responses after a timeout are soaked up in IDLE.
  assign idle_bready = 1'b1;
  assign tmo_hit     = (state_q == ST_BRSP) && !axi_bvalid_i && (tmo_q == TW'(TMO));
  assign tmo_d       = (state_q == ST_BRSP) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign idle_bready = 1'b0;
  // TMO only sizes the watchdog; without it a timeout can never fire.
  assign tmo_hit     = (TMO < 0);
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    req_ready_o   = '0;
    req_wready_o  = '0;
    req_done_o    = '0;
    req_err_o     = '0;
    axi_awvalid_o = 1'b0;
    axi_awaddr_o  = '0;
    axi_awlen_o   = '0;
    axi_awid_o    = '0;
    axi_awsize_o  = '0;
    axi_awburst_o = '0;
    axi_wvalid_o  = 1'b0;
    axi_wdata_o   = '0;
    axi_wstrb_o   = '0;
    axi_wid_o     = '0;
    axi_wlast_o   = 1'b0;
    axi_bready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        axi_bready_o = idle_bready;
        if (arb_any) begin
          grant_d = arb_idx;
          addr_d  = req_addr_i[int'(arb_idx)*AW +: AW];
          len_d   = req_len_i[int'(arb_idx)*HP_LEN_W +: HP_LEN_W];
          state_d = ST_AWR;
        end
      end
      ST_AWR: begin
        axi_awvalid_o = 1'b1;
        axi_awaddr_o  = addr_q;
        axi_awlen_o   = len_q;
        axi_awid_o    = grant_id;
        axi_awsize_o  = AXSIZE;
        axi_awburst_o = BURST_INCR;
        if (axi_awready_i) begin
          req_ready_o = grant_oh;
          cnt_d       = len_q;
          state_d     = ST_WDAT;
        end
      end
      ST_WDAT: begin
        axi_wvalid_o = req_wvalid_i[grant_q];
        axi_wdata_o  = req_wdata_i[int'(grant_q)*DW +: DW];
        axi_wstrb_o  = req_wstrb_i[int'(grant_q)*SW +: SW];
        axi_wid_o    = grant_id;
        axi_wlast_o  = (cnt_q == '0);
        req_wready_o = axi_wready_i ? grant_oh : '0;
        if (axi_wvalid_o && axi_wready_i) begin
          if (cnt_q == '0) state_d = ST_BRSP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_BRSP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i || tmo_hit) begin
          req_done_o = grant_oh;
          // A mismatched BID still closes the burst but is flagged as an error.
          if (tmo_hit || (axi_bresp_i != BRESP_OKAY) || (axi_bid_i != grant_id))
            req_err_o = grant_oh;
          ptr_d   = (grant_q == GW'(RN - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_hp_wr_arb.sv
// Directed bench for axi_hp_wr_arb (RN=2); the timeout steps run when AXI_HP_WR_ARB_TMO_EN is defined.
module tb_axi_hp_wr_arb;
  import axi_hp_pkg::*;

  localparam int RN  = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;
`ifdef AXI_HP_WR_ARB_TMO_EN
  localparam logic IDLE_BREADY = 1'b1;
`else
  localparam logic IDLE_BREADY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RN-1:0]        req_valid, req_ready, req_wvalid, req_wready, req_done, req_err;
  logic [RN*AW-1:0]     req_addr;
  logic [RN*4-1:0]      req_len;
  logic [RN*DW-1:0]     req_wdata;
  logic [RN*SW-1:0]     req_wstrb;
  logic [0:0]           grant;
  logic                 busy;
  state_e               dbg_state;
  logic [AW-1:0]        awaddr;
  logic [3:0]           awlen;
  logic [5:0]           awid, wid, bid;
  logic [2:0]           awsize;
  logic [1:0]           awburst, bresp;
  logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]        wdata;
  logic [SW-1:0]        wstrb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_hp_wr_arb #(.RN(RN), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .req_wvalid_i(req_wvalid), .req_wready_o(req_wready), .req_done_o(req_done),
    .req_err_o(req_err), .grant_o(grant), .busy_o(busy), .dbg_state_o(dbg_state),
    .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awid_o(awid),
    .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awvalid_o(awvalid),
    .axi_awready_i(awready), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_wid_o(wid), .axi_wlast_o(wlast), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int r, input int b);
    return 64'hDA7A_0000_0000_0000 | (64'(r) << 32) | 64'(b);
  endfunction

  function automatic logic [AW-1:0] addr_of(input int r);
    return (r == 0) ? 32'h1000_0000 : 32'h2000_0400;
  endfunction

  function automatic logic [SW-1:0] strb_of(input int r);
    return (r == 0) ? 8'hFF : 8'h0F;
  endfunction

  task automatic set_wdata(input int b);
    for (int r = 0; r < RN; r++) req_wdata[r*DW +: DW] = pat(r, b);
  endtask

  // Call in IDLE with req_valid[g] already set; returns one cycle into IDLE after the B handshake.
  task automatic run_burst(input int g, input int len, input bit bp,
                           input logic [1:0] rsp, input logic [5:0] rid, input logic exp_err);
    req_len[g*4 +: 4] = 4'(len);
    if (bp) awready = 1'b0;
    cyc();
    chk("aw_valid", awvalid, 1);
    chk("grant", grant, g);
    chk("aw_addr", awaddr, addr_of(g));
    chk("aw_len", awlen, len);
    chk("aw_id", awid, g);
    chk("aw_size", awsize, 3);
    chk("aw_burst", awburst, 1);
    if (bp) begin
      chk("aw_stall_ready", req_ready, 0);
      cyc();
      awready = 1'b1;
      #1;
      chk("aw_stall_hold_addr", awaddr, addr_of(g));
    end
    chk("req_ready", req_ready, 64'(1) << g);
    for (int b = 0; b <= len; b++) begin
      cyc();
      set_wdata(b);
      if (bp) begin
        wready = 1'b0;
        #1;
        chk("bp_wready", req_wready, 0);
        chk("bp_wlast", wlast, (b == len));
        cyc();
        wready = 1'b1;
        req_wvalid[g] = 1'b0;
        #1;
        chk("gap_wvalid", wvalid, 0);
        cyc();
        req_wvalid[g] = 1'b1;
      end
      #1;
      chk("w_valid", wvalid, 1);
      chk("w_data", wdata, pat(g, b));
      chk("w_strb", wstrb, strb_of(g));
      chk("w_id", wid, g);
      chk("w_last", wlast, (b == len));
      chk("w_ready_onehot", req_wready, 64'(1) << g);
    end
    cyc();
    chk("b_ready", bready, 1);
    chk("b_wvalid_off", wvalid, 0);
    chk("b_done_wait", req_done, 0);
    bvalid = 1'b1;
    bresp  = rsp;
    bid    = rid;
    #1;
    chk("done", req_done, 64'(1) << g);
    chk("err", req_err, 64'(exp_err) << g);
    cyc();
    bvalid = 1'b0;
    bresp  = 2'b00;
    bid    = '0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", req_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int first_err;
    logic done_at_err;
    rst = 1'b1;
    req_valid = '0; req_wvalid = '1; req_len = '0; req_wdata = '0;
    req_addr = {addr_of(1), addr_of(0)};
    req_wstrb = {strb_of(1), strb_of(0)};
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = '0; bid = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, IDLE_BREADY);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wready", req_wready, 0);

    // Single request: one-cycle latency to AWVALID, 4 zero-wait beats.
    req_valid = 2'b01;
    #1;
    chk("latency_awvalid", awvalid, 0);
    run_burst(0, 3, 1'b0, 2'b00, 6'd0, 1'b0);
    req_valid = 2'b00;

    // Contention: pointer sits at 1, grants alternate.
    cyc();
    req_valid = 2'b11;
    run_burst(1, 1, 1'b0, 2'b00, 6'd1, 1'b0);
    run_burst(0, 0, 1'b0, 2'b00, 6'd0, 1'b0);
    run_burst(1, 2, 1'b0, 2'b00, 6'd1, 1'b0);
    run_burst(0, 1, 1'b0, 2'b00, 6'd0, 1'b0);
    req_valid = 2'b00;

    // Backpressure on AW and W, with wvalid gaps.
    cyc();
    req_valid = 2'b10;
    run_burst(1, 2, 1'b1, 2'b00, 6'd1, 1'b0);
    req_valid = 2'b00;

    // SLVERR, then a clean burst, then a BID mismatch.
    cyc();
    req_valid = 2'b01;
    run_burst(0, 0, 1'b0, 2'b10, 6'd0, 1'b1);
    req_valid = 2'b11;
    run_burst(1, 0, 1'b0, 2'b00, 6'd1, 1'b0);
    req_valid = 2'b01;
    run_burst(0, 0, 1'b0, 2'b00, 6'd5, 1'b1);
    req_valid = 2'b00;

    // Reset in WDAT after 2 of 8 beats; pointer must restart at 0.
    cyc();
    req_valid = 2'b10;
    req_len[4 +: 4] = 4'd7;
    cyc();
    chk("mr_grant", grant, 1);
    cyc(); set_wdata(0); #1; chk("mr_wlast0", wlast, 0);
    cyc(); set_wdata(1); #1; chk("mr_wlast1", wlast, 0);
    cyc();
    chk("mr_busy", busy, 1);
    rst = 1'b1;
    cyc();
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_wvalid", wvalid, 0);
    chk("mr_rst_wdata", wdata, 0);
    chk("mr_rst_wready", req_wready, 0);
    chk("mr_rst_awvalid", awvalid, 0);
    chk("mr_rst_grant", grant, 0);
    chk("mr_rst_bready", bready, IDLE_BREADY);
    chk("mr_rst_done", req_done, 0);
    rst = 1'b0;
    req_valid = 2'b11;
    run_burst(0, 0, 1'b0, 2'b00, 6'd0, 1'b0);
    req_valid = 2'b00;

`ifdef AXI_HP_WR_ARB_TMO_EN
    // Withheld B: timeout fires TMO cycles after entering BRSP.
    cyc();
    req_valid = 2'b01;
    req_len[3:0] = 4'd0;
    cyc();
    chk("tmo_aw", awvalid, 1);
    req_valid = 2'b00;
    cyc();
    chk("tmo_wlast", wlast, 1);
    cyc();
    chk("tmo_in_brsp", dbg_state, ST_BRSP);
    first_err = -1;
    done_at_err = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (req_err[0]) begin
        first_err = k;
        done_at_err = req_done[0];
        break;
      end
      cyc();
    end
    chk("tmo_cycle", 64'(first_err), 64'(TMO));
    chk("tmo_done", done_at_err, 1);
    cyc();
    chk("tmo_idle", busy, 0);
    chk("tmo_idle_bready", bready, 1);
    bvalid = 1'b1;
    #1;
    chk("late_b_done", req_done, 0);
    cyc();
    bvalid = 1'b0;
    chk("late_b_busy", busy, 0);
`else
    first_err = 0;
    done_at_err = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
